// File: rtl/sr_drive_ctrl.sv
// -----------------------------------------------------------------------------
// sr_drive_ctrl
//
// Command front-end for a downstream SR flip-flop (srff). Converts one-cycle
// set/clear requests into mutually exclusive s/r pulses PULSE_W cycles wide.
// It then watches the flop's q feedback and reports done, or reports an error
// on timeout. A request with both set and clear high is rejected with an error.
// The downstream flop never sees s=r=1.
//
// Optional feature macro: SR_ERRCNT_EN
//   defined   : o_err_cnt counts err pulses and saturates at 255 (cleared by rst)
//   undefined : o_err_cnt is tied to 0 and no counter is built
//
// Parameters:
//   PULSE_W  cycles s or r is held high per command (>= 1)
//   TIMEOUT  max CHECK cycles waiting for q_fb to match the target (>= 1)
//   CNT_W    counter width, must hold max(PULSE_W, TIMEOUT)
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_set_req   request q=1 (sampled only when idle)
//   i_clr_req   request q=0 (sampled only when idle)
//   i_q_fb      q from the downstream srff
//   o_s         set drive to the srff
//   o_r         reset drive to the srff
//   o_busy      command in progress
//   o_done      one-cycle pulse: q_fb matched the target
//   o_err       one-cycle pulse: command rejected or timed out
//   o_err_type  01 = both requests, 10 = timeout; held until next err or rst
//   o_err_cnt   saturating error count (0 when SR_ERRCNT_EN is undefined)
// -----------------------------------------------------------------------------
module sr_drive_ctrl #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned TIMEOUT = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_set_req,
    input  logic       i_clr_req,
    input  logic       i_q_fb,
    output logic       o_s,
    output logic       o_r,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [1:0] o_err_type,
    output logic [7:0] o_err_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [1:0] ERR_BOTH    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Terminal counter values: the counter runs 0..LAST inside a state.
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_target;
    logic             w_target_nxt;
    logic             r_s;
    logic             w_s_nxt;
    logic             r_r;
    logic             w_r_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [1:0]       r_err_type;
    logic [1:0]       w_err_type_nxt;

    logic w_req_one;
    logic w_req_both;

    assign w_req_one  = i_set_req ^ i_clr_req;
    assign w_req_both = i_set_req & i_clr_req;

    // Next-state logic. s/r are registered so they change only on clock edges
    // (or drop on reset); their next values come from mutually exclusive terms.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_target_nxt   = r_target;
        w_s_nxt        = 1'b0;
        w_r_nxt        = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_type_nxt = r_err_type;

        case (r_state)
            ST_IDLE: begin
                if (w_req_both) begin
                    w_err_nxt      = 1'b1;
                    w_err_type_nxt = ERR_BOTH;
                end else if (w_req_one) begin
                    w_state_nxt  = ST_DRIVE;
                    w_target_nxt = i_set_req;
                    w_cnt_nxt    = '0;
                    w_s_nxt      = i_set_req;
                    w_r_nxt      = i_clr_req;
                end
            end

            ST_DRIVE: begin
                if (r_cnt == PULSE_LAST) begin
                    // Pulse ends on this edge; s/r fall with the state change.
                    w_state_nxt = ST_CHECK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    w_s_nxt   = r_target;
                    w_r_nxt   = ~r_target;
                end
            end

            ST_CHECK: begin
                if (i_q_fb == r_target) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_err_nxt      = 1'b1;
                    w_err_type_nxt = ERR_TIMEOUT;
                    w_state_nxt    = ST_IDLE;
                    w_cnt_nxt      = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_target   <= 1'b0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_type <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_target   <= w_target_nxt;
            r_s        <= w_s_nxt;
            r_r        <= w_r_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_type <= w_err_type_nxt;
        end
    end

    assign o_s        = r_s;
    assign o_r        = r_r;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_err_type = r_err_type;

`ifdef SR_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Counts with the err pulse itself so o_err_cnt moves on the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    assign o_err_cnt = 8'd0;
`endif

`ifndef SYNTHESIS
    a_sr_exclusive: assert property (@(posedge i_clk) !(o_s && o_r));
    a_done_err_exclusive: assert property (@(posedge i_clk) disable iff (i_rst)
        !(o_done && o_err));
`endif

endmodule
